cv_output_framer: RTL

//  Downstream neighbour of the 3-stage encryption pipeline. Consumes 16-bit ciphertext

---
 rtl/cv_output_framer.sv | 110 +++++++++++
 1 files changed

// File: rtl/cv_output_framer.sv
// Frames 16-bit ciphertext words into bytes: header, MSB-first data bytes, then an XOR checksum byte.
// Latency: the header appears 2 cycles after the first word is accepted; one byte per cycle after that.
// Backpressure: out_* holds stable while out_ready is low; in_ready only falls while the single hold word is still unsent.
module cv_output_framer #(
    parameter int          FRAME_WORDS = 4,
    parameter logic [7:0]  HEADER      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {IDLE, HDR, HI, LO, CHK} state_t;

    state_t      state;
    logic        hold_vld;
    logic [15:0] hold_data;
    logic [7:0]  chk;
    logic [7:0]  word_cnt;
    logic        in_acc;
    logic        out_fire;
    logic        last_word;

    // The low byte leaving the hold register frees it in the same cycle, so the
    // next word can load without a bubble.
    assign in_ready  = !hold_vld || (state == LO && out_ready);
    assign in_acc    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_word = (word_cnt == 8'(FRAME_WORDS - 1));

    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_sof   = 1'b0;
        out_eof   = 1'b0;
        case (state)
            HDR: begin
                out_valid = 1'b1;
                out_data  = HEADER;
                out_sof   = 1'b1;
            end
            HI: begin
                out_valid = hold_vld;
                out_data  = hold_data[15:8];
            end
            LO: begin
                out_valid = 1'b1;
                out_data  = hold_data[7:0];
            end
            CHK: begin
                out_valid = 1'b1;
                out_data  = chk;
                out_eof   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_vld  <= 1'b0;
            hold_data <= 16'h0000;
            chk       <= 8'h00;
            word_cnt  <= 8'h00;
            frame_cnt <= 16'h0000;
        end else begin
            if (in_acc) begin
                hold_data <= in_data;
                hold_vld  <= 1'b1;
            end else if (state == LO && out_fire) begin
                hold_vld  <= 1'b0;
            end

            case (state)
                IDLE: if (hold_vld) state <= HDR;
                HDR:  if (out_fire) state <= HI;
                HI: if (out_fire) begin
                    chk   <= chk ^ out_data;
                    state <= LO;
                end
                LO: if (out_fire) begin
                    chk <= chk ^ out_data;
                    if (last_word) begin
                        word_cnt <= 8'h00;
                        state    <= CHK;
                    end else begin
                        word_cnt <= word_cnt + 8'd1;
                        state    <= HI;
                    end
                end
                CHK: if (out_fire) begin
                    chk       <= 8'h00;
                    frame_cnt <= frame_cnt + 16'd1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
